// File: rtl/rs_encoder.sv
// rs_encoder: symbol-serial systematic RS(7,5) encoder over GF(8)
//   (primitive polynomial x^3+x+1, generator g(x) = x^2 + a^4*x + a^3).
//
// Symbol bit [2] holds the a^0 coefficient, bit [1] a^1, bit [0] a^2.
// Five message symbols (m4 first) are accepted on in_valid/in_ready and
// streamed straight through. The two parity symbols p1, p0 follow.
// The full 21-bit codeword {m4..m0,p1,p0} is also assembled in parallel.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   in_valid       in_symbol is valid
//   in_ready       encoder accepts in_symbol this cycle (no path from in_valid)
//   in_symbol      message symbol, m4 first
//   out_valid      out_symbol is valid
//   out_ready      downstream accepts out_symbol this cycle
//   out_symbol     codeword symbol, order m4..m0, p1, p0
//   out_last       high while p0 is presented
//   codeword       assembled codeword, m4 at [20:18], p0 at [2:0]
//   codeword_valid one-cycle pulse when codeword is complete
//   busy           message partially accepted or parity pending
module rs_encoder #(
  parameter int N            = 7,
  parameter int K            = 5,
  parameter int SYMBOL_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SYMBOL_WIDTH-1:0]     in_symbol,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SYMBOL_WIDTH-1:0]     out_symbol,
  output logic                        out_last,
  output logic [N*SYMBOL_WIDTH-1:0]   codeword,
  output logic                        codeword_valid,
  output logic                        busy
);

  localparam int CNT_W = $clog2(K + 1);

  typedef enum logic [1:0] {
    MSG  = 2'd0,
    PAR1 = 2'd1,
    PAR0 = 2'd2
  } state_t;

  // Multiply by a: c0 + c1*a + c2*a^2 -> c2 + (c0^c2)*a + c1*a^2.
  function automatic logic [2:0] gf_mul_a(input logic [2:0] b);
    return {b[0], b[2] ^ b[0], b[1]};
  endfunction

  function automatic logic [2:0] gf_mul_a3(input logic [2:0] b);
    return gf_mul_a(gf_mul_a(gf_mul_a(b)));
  endfunction

  function automatic logic [2:0] gf_mul_a4(input logic [2:0] b);
    return gf_mul_a(gf_mul_a3(b));
  endfunction

  state_t                    state_p0, state_n;
  logic [CNT_W-1:0]          cnt_p0, cnt_n;
  logic [SYMBOL_WIDTH-1:0]   r1_p0, r1_n;
  logic [SYMBOL_WIDTH-1:0]   r0_p0, r0_n;
  logic [SYMBOL_WIDTH-1:0]   fb;
  logic [SYMBOL_WIDTH-1:0]   load_sym;
  logic                      out_free;
  logic                      accept;
  logic                      load;
  logic                      load_last;
  logic                      cw_pulse;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_p0 == MSG) && out_free;
  assign busy     = (cnt_p0 != '0) || (state_p0 != MSG);

  always_comb begin
    state_n   = state_p0;
    cnt_n     = cnt_p0;
    r1_n      = r1_p0;
    r0_n      = r0_p0;
    load      = 1'b0;
    load_sym  = out_symbol;
    load_last = 1'b0;
    cw_pulse  = 1'b0;
    accept    = in_valid && (state_p0 == MSG) && out_free;
    fb        = in_symbol ^ r1_p0;

    case (state_p0)
      MSG: begin
        if (accept) begin
          load     = 1'b1;
          load_sym = in_symbol;
          r1_n     = r0_p0 ^ gf_mul_a4(fb);
          r0_n     = gf_mul_a3(fb);
          cnt_n    = cnt_p0 + CNT_W'(1);
          if (cnt_p0 == CNT_W'(K - 1)) state_n = PAR1;
        end
      end
      PAR1: begin
        if (out_free) begin
          load     = 1'b1;
          load_sym = r1_p0;
          state_n  = PAR0;
        end
      end
      PAR0: begin
        if (out_free) begin
          load      = 1'b1;
          load_sym  = r0_p0;
          load_last = 1'b1;
          cw_pulse  = 1'b1;
          r1_n      = '0;
          r0_n      = '0;
          cnt_n     = '0;
          state_n   = MSG;
        end
      end
      default: state_n = MSG;
    endcase
  end

  // Stage p0: LFSR, control and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0       <= MSG;
      cnt_p0         <= '0;
      r1_p0          <= '0;
      r0_p0          <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_symbol     <= '0;
      codeword       <= '0;
      codeword_valid <= 1'b0;
    end else begin
      state_p0       <= state_n;
      cnt_p0         <= cnt_n;
      r1_p0          <= r1_n;
      r0_p0          <= r0_n;
      codeword_valid <= cw_pulse;
      if (load) begin
        out_valid  <= 1'b1;
        out_last   <= load_last;
        out_symbol <= load_sym;
        codeword   <= {codeword[N*SYMBOL_WIDTH-SYMBOL_WIDTH-1:0], load_sym};
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// tb_rs_encoder: scoreboard bench for rs_encoder. Stimulus pushes expected
// symbols/codewords into queues; a negedge monitor pops and compares.
module tb_rs_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_symbol;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_symbol;
  logic        out_last;
  logic [20:0] codeword;
  logic        codeword_valid;
  logic        busy;

  rs_encoder #(.N(7), .K(5), .SYMBOL_WIDTH(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_symbol      (in_symbol),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_symbol     (out_symbol),
    .out_last       (out_last),
    .codeword       (codeword),
    .codeword_valid (codeword_valid),
    .busy           (busy)
  );

  localparam logic [2:0] EXP [7] = '{3'b100, 3'b010, 3'b001, 3'b110,
                                     3'b011, 3'b111, 3'b101};
  localparam logic [2:0] G1 = 3'b011;  // a^4
  localparam logic [2:0] G0 = 3'b110;  // a^3

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int cyc      = 0;
  logic sb_en  = 1'b1;
  logic meas   = 1'b0;
  logic rnd_ready = 1'b0;

  logic [3:0]  sym_q [$];
  logic [20:0] cw_q  [$];
  int          gap_q [$];
  int          low_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    int la, lb;
    if (a == 3'b000 || b == 3'b000) return 3'b000;
    la = 0;
    lb = 0;
    for (int i = 0; i < 7; i++) begin
      if (EXP[i] == a) la = i;
      if (EXP[i] == b) lb = i;
    end
    return EXP[(la + lb) % 7];
  endfunction

  // Long division of m(x)*x^2 by g(x).
  function automatic logic [20:0] ref_cw(input logic [14:0] msg);
    logic [2:0] c [7];
    logic [2:0] q;
    for (int i = 0; i < 5; i++) c[i + 2] = msg[i*3 +: 3];
    c[1] = 3'b000;
    c[0] = 3'b000;
    for (int i = 6; i >= 2; i--) begin
      q        = c[i];
      c[i-1]   = c[i-1] ^ gmul(q, G1);
      c[i-2]   = c[i-2] ^ gmul(q, G0);
      c[i]     = 3'b000;
    end
    return {msg, c[1], c[0]};
  endfunction

  // Evaluate c(x) at a^j by Horner; a valid codeword gives 0 for j=1,2.
  function automatic logic [2:0] syndrome(input logic [20:0] cw, input int j);
    logic [2:0] acc;
    acc = 3'b000;
    for (int i = 6; i >= 0; i--) acc = gmul(acc, EXP[j]) ^ cw[i*3 +: 3];
    return acc;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor
  initial begin
    logic [3:0]  e;
    logic [20:0] ec;
    int prev_cyc;
    int low_cnt;
    logic have_prev;
    have_prev = 1'b0;
    low_cnt   = 0;
    prev_cyc  = 0;
    forever begin
      @(negedge clk);
      if (sb_en && out_valid && out_ready) begin
        if (sym_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_symbol: got %0h expected none", out_symbol);
        end else begin
          e = sym_q.pop_front();
          check("out_symbol", {29'd0, out_symbol}, {29'd0, e[2:0]});
          check("out_last", {31'd0, out_last}, {31'd0, e[3]});
        end
      end
      if (meas && !in_ready) low_cnt++;
      if (codeword_valid) begin
        pulses++;
        check("last_with_pulse", {31'd0, out_last}, 32'd1);
        check("syndrome1", {29'd0, syndrome(codeword, 1)}, 32'd0);
        check("syndrome2", {29'd0, syndrome(codeword, 2)}, 32'd0);
        if (sb_en) begin
          if (cw_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_codeword: got %0h expected none", codeword);
          end else begin
            ec = cw_q.pop_front();
            check("codeword", {11'd0, codeword}, {11'd0, ec});
          end
        end
        if (meas) begin
          if (have_prev) begin
            gap_q.push_back(cyc - prev_cyc);
            low_q.push_back(low_cnt);
          end
          have_prev = 1'b1;
          prev_cyc  = cyc;
          low_cnt   = 0;
        end
      end
    end
  end

  task automatic send_msg(input logic [14:0] msg, input logic [20:0] exp_cw, input int bubble_pct);
    int  i;
    int  guard;
    logic hs;
    for (int k = 4; k >= 0; k--) sym_q.push_back({1'b0, msg[k*3 +: 3]});
    sym_q.push_back({1'b0, exp_cw[5:3]});
    sym_q.push_back({1'b1, exp_cw[2:0]});
    cw_q.push_back(exp_cw);
    i = 0;
    guard = 0;
    while (i < 5) begin
      in_valid  = ($urandom_range(0, 99) >= bubble_pct);
      in_symbol = msg[(4 - i)*3 +: 3];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        check("pass_valid", {31'd0, out_valid}, 32'd1);
        check("pass_symbol", {29'd0, out_symbol}, {29'd0, msg[(4 - i)*3 +: 3]});
        i++;
      end
      guard++;
      if (guard > 2000) begin
        $display("FAIL accept_timeout: got %0d symbols expected 5", i);
        $fatal(1, "accept timeout");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sym_q.size() != 0 || cw_q.size() != 0) && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", sym_q.size() + cw_q.size(), 32'd0);
  endtask

  initial begin
    logic [14:0] msg;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_symbol = 3'b000;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset then idle
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_codeword", {11'd0, codeword}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_out_symbol", {29'd0, out_symbol}, 32'd0);
    check("idle_pulses", pulses, 32'd0);

    // Directed vectors
    send_msg(15'b100_000_000_000_000, 21'h10001A, 0);
    drain();
    check("single_pulse", pulses, 32'd1);
    send_msg(15'b000_000_000_000_100, 21'h00011E, 0);
    send_msg(15'b100_000_000_000_100, 21'h100104, 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("codeword_hold", {11'd0, codeword}, 32'h100104);
    check("idle_after_busy", {31'd0, busy}, 32'd0);

    // Back-to-back throughput
    meas = 1'b1;
    send_msg(15'h1234, ref_cw(15'h1234), 0);
    send_msg(15'h7FFF, ref_cw(15'h7FFF), 0);
    send_msg(15'h0A5C, ref_cw(15'h0A5C), 0);
    send_msg(15'h5001, ref_cw(15'h5001), 0);
    drain();
    meas = 1'b0;
    check("gap_count", gap_q.size(), 32'd3);
    foreach (gap_q[k]) check("pulse_spacing", gap_q[k], 32'd7);
    foreach (low_q[k]) check("in_ready_low", low_q[k], 32'd2);

    // Random backpressure and bubbles
    rnd_ready = 1'b1;
    for (int m = 0; m < 20; m++) begin
      msg = 15'($urandom);
      send_msg(msg, ref_cw(msg), 30);
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("random_pulses", pulses, 32'd27);

    // Reset after the third accepted symbol
    sb_en     = 1'b0;
    in_valid  = 1'b1;
    in_symbol = 3'b101;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_symbol", {29'd0, out_symbol}, 32'd0);
    check("rst_codeword", {11'd0, codeword}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sym_q.delete();
    cw_q.delete();
    sb_en = 1'b1;
    send_msg(15'b100_000_000_000_000, 21'h10001A, 0);
    drain();
    check("post_reset_codeword", {11'd0, codeword}, 32'h10001A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
